// File: rtl/raster_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : raster_ctrl_pkg
// Brief    : Shared raster-control types (frame scheduler state encoding)
// Revision : 1.0
// ============================================================================
package raster_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RENDER = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } frame_sched_state_t;

    // A frame is in flight while the renderer works or its writes settle.
    function automatic logic is_busy(input frame_sched_state_t s);
        return (s == RENDER) || (s == DRAIN);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_sync.sv
`default_nettype none
// ============================================================================
// Module   : pulse_sync
// Brief    : 2-flop level synchronizer with registered rising-edge pulse
// Revision : 1.0
// ============================================================================
module pulse_sync (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic       r_meta;
    logic       r_sync;
    logic       r_prev;
    logic       r_armed;
    logic [1:0] r_fill;
    logic       r_pulse;

    // r_fill marks when r_sync holds a real sample; the detector only arms
    // after it has seen the level low, so a level already high at reset
    // release never counts as an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta  <= 1'b0;
            r_sync  <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_fill  <= 2'b00;
            r_pulse <= 1'b0;
        end else begin
            r_meta  <= level;
            r_sync  <= r_meta;
            r_prev  <= r_sync;
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & ~r_sync);
            r_pulse <= r_armed & r_sync & ~r_prev;
        end
    end

    assign pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_scheduler
// Brief    : vsync-paced render / drain / swap sequencer for a double buffer
// Revision : 1.0
// ============================================================================
module frame_scheduler
    import raster_ctrl_pkg::*;
#(
    parameter int unsigned DRAIN_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_pix,
    input  logic             draw_done,
    input  logic             renderer_busy,
    input  logic             pipe_valid,
    output logic             begin_frame,
    output logic             swap,
    output logic [CNT_W-1:0] frame_count,
    output logic [CNT_W-1:0] drop_count,
    output logic             timeout_err,
    output logic             busy
);

    localparam int unsigned c_wd_w   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned c_idle_w = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [c_wd_w-1:0]   c_wd_last   = c_wd_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_idle_w-1:0] c_idle_last = c_idle_w'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]    c_cnt_max   = {CNT_W{1'b1}};

    frame_sched_state_t  r_state;
    logic                r_begin;
    logic                r_swap;
    logic [CNT_W-1:0]    r_frame_cnt;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic                r_timeout;
    logic [c_wd_w-1:0]   r_wdog;
    logic [c_idle_w-1:0] r_idle;
    logic                w_vsync_p;

    pulse_sync u_vsync_sync (
        .clk   (clk),
        .rst   (rst),
        .level (frame_pix),
        .pulse (w_vsync_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_begin     <= 1'b0;
            r_swap      <= 1'b0;
            r_frame_cnt <= '0;
            r_drop_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_wdog      <= '0;
            r_idle      <= '0;
        end else begin
            r_begin <= 1'b0;
            r_swap  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_vsync_p) begin
                        r_begin <= 1'b1;
                        r_wdog  <= '0;
                        r_state <= RENDER;
                    end
                end
                RENDER: begin
                    r_wdog <= r_wdog + c_wd_w'(1);
                    if (w_vsync_p && (r_drop_cnt != c_cnt_max)) begin
                        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end
                    if (draw_done) begin
                        r_idle  <= '0;
                        r_state <= DRAIN;
                    end
                    if (r_wdog == c_wd_last) begin
                        r_timeout <= 1'b1;
                        r_idle    <= '0;
                        r_state   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_vsync_p && (r_drop_cnt != c_cnt_max)) begin
                        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end
                    // Any busy or in-flight cycle restarts the quiet window.
                    if (!renderer_busy && !pipe_valid) begin
                        if (r_idle == c_idle_last) begin
                            r_state <= DONE;
                        end else begin
                            r_idle <= r_idle + c_idle_w'(1);
                        end
                    end else begin
                        r_idle <= '0;
                    end
                end
                DONE: begin
                    if (w_vsync_p) begin
                        r_begin     <= 1'b1;
                        r_swap      <= 1'b1;
                        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        r_wdog      <= '0;
                        r_state     <= RENDER;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign begin_frame = r_begin;
    assign swap        = r_swap;
    assign frame_count = r_frame_cnt;
    assign drop_count  = r_drop_cnt;
    assign timeout_err = r_timeout;
    assign busy        = is_busy(r_state);

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_scheduler
// Brief    : Table-driven self-checking bench with a pulse scoreboard
// Revision : 1.0
// ============================================================================
module tb_frame_scheduler;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          frame_pix = 1'b0;
    logic          draw_done = 1'b0;
    logic          renderer_busy = 1'b0;
    logic          pipe_valid = 1'b0;
    logic          begin_frame;
    logic          swap;
    logic [CW-1:0] frame_count;
    logic [CW-1:0] drop_count;
    logic          timeout_err;
    logic          busy;

    int cyc    = 0;
    int n_chk  = 0;
    int n_pass = 0;

    typedef enum {OP_WAIT, OP_DRAW, OP_VSYNC, OP_COMBO} op_e;

    typedef struct {
        op_e           op;
        int            n;
        logic          rb;
        logic          pv;
        logic          st;
        logic          sw;
        logic [CW-1:0] fc;
        logic [CW-1:0] dc;
        logic          bz;
        logic          to;
    } step_t;

    typedef struct {
        logic          sw;
        logic [CW-1:0] fc;
        int            at;
    } ev_t;

    ev_t sb_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_scheduler #(
        .DRAIN_CYCLES   (4),
        .TIMEOUT_CYCLES (50),
        .CNT_W          (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_pix     (frame_pix),
        .draw_done     (draw_done),
        .renderer_busy (renderer_busy),
        .pipe_valid    (pipe_valid),
        .begin_frame   (begin_frame),
        .swap          (swap),
        .frame_count   (frame_count),
        .drop_count    (drop_count),
        .timeout_err   (timeout_err),
        .busy          (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic step_t mk(op_e op, int n, bit rb, bit pv, bit st, bit sw,
                                 int fc, int dc, bit bz, bit to);
        step_t s;
        s.op = op; s.n = n; s.rb = rb; s.pv = pv; s.st = st; s.sw = sw;
        s.fc = CW'(fc); s.dc = CW'(dc); s.bz = bz; s.to = to;
        return s;
    endfunction

    // Every begin_frame/swap pulse must match the oldest expected start.
    always @(negedge clk) begin : mon
        ev_t e;
        if (begin_frame || swap) begin
            check("pulse_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("pulse_begin", 32'(begin_frame), 32'd1);
                check("pulse_swap", 32'(swap), 32'(e.sw));
                check("pulse_frame_count", 32'(frame_count), 32'(e.fc));
                check("pulse_cycle", 32'(cyc), 32'(e.at));
                check("pulse_busy", 32'(busy), 32'd1);
            end
        end
    end

    task automatic run_step(input int idx, input step_t s);
        ev_t e;
        renderer_busy = s.rb;
        pipe_valid    = s.pv;
        case (s.op)
            OP_WAIT: wait_neg(s.n);
            OP_DRAW: begin
                draw_done = 1'b1;
                wait_neg(1);
                draw_done = 1'b0;
            end
            OP_VSYNC: begin
                for (int k = 0; k < s.n; k++) begin
                    frame_pix = 1'b1;
                    if (s.st) begin
                        e.sw = s.sw; e.fc = s.fc; e.at = cyc + 4;
                        sb_q.push_back(e);
                    end
                    wait_neg(6);
                    frame_pix = 1'b0;
                    wait_neg(4);
                end
            end
            OP_COMBO: begin
                // draw_done lands on the same edge that samples vsync_p
                frame_pix = 1'b1;
                wait_neg(3);
                draw_done = 1'b1;
                wait_neg(1);
                draw_done = 1'b0;
                wait_neg(2);
                frame_pix = 1'b0;
                wait_neg(4);
            end
            default: wait_neg(1);
        endcase
        check($sformatf("s%0d_busy", idx), 32'(busy), 32'(s.bz));
        check($sformatf("s%0d_frame_count", idx), 32'(frame_count), 32'(s.fc));
        check($sformatf("s%0d_drop_count", idx), 32'(drop_count), 32'(s.dc));
        check($sformatf("s%0d_timeout_err", idx), 32'(timeout_err), 32'(s.to));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        step_t tbl[22];
        //             op        n  rb pv st sw fc dc bz to
        tbl[0]  = mk(OP_WAIT,   3, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(OP_VSYNC,  1, 0, 0, 1, 0, 0, 0, 1, 0);
        tbl[2]  = mk(OP_WAIT,  10, 1, 0, 0, 0, 0, 0, 1, 0);
        tbl[3]  = mk(OP_DRAW,   1, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[4]  = mk(OP_WAIT,   6, 0, 0, 0, 0, 0, 0, 0, 0);
        tbl[5]  = mk(OP_VSYNC,  1, 0, 0, 1, 1, 1, 0, 1, 0);
        tbl[6]  = mk(OP_DRAW,   1, 1, 0, 0, 0, 1, 0, 1, 0);
        tbl[7]  = mk(OP_VSYNC,  1, 1, 0, 0, 0, 1, 1, 1, 0);
        tbl[8]  = mk(OP_VSYNC,  1, 0, 1, 0, 0, 1, 2, 1, 0);
        tbl[9]  = mk(OP_VSYNC,  1, 1, 1, 0, 0, 1, 3, 1, 0);
        tbl[10] = mk(OP_WAIT,   3, 0, 0, 0, 0, 1, 3, 1, 0);
        tbl[11] = mk(OP_WAIT,   1, 0, 0, 0, 0, 1, 3, 0, 0);
        tbl[12] = mk(OP_VSYNC,  1, 0, 0, 1, 1, 2, 3, 1, 0);
        tbl[13] = mk(OP_WAIT,  43, 1, 0, 0, 0, 2, 3, 1, 0);
        tbl[14] = mk(OP_WAIT,   1, 1, 0, 0, 0, 2, 3, 1, 1);
        tbl[15] = mk(OP_WAIT,   4, 0, 0, 0, 0, 2, 3, 0, 1);
        tbl[16] = mk(OP_VSYNC,  1, 0, 0, 1, 1, 3, 3, 1, 1);
        tbl[17] = mk(OP_COMBO,  1, 1, 0, 0, 0, 3, 4, 1, 1);
        tbl[18] = mk(OP_WAIT,   5, 0, 0, 0, 0, 3, 4, 0, 1);
        tbl[19] = mk(OP_VSYNC,  1, 0, 0, 1, 1, 4, 4, 1, 1);
        tbl[20] = mk(OP_VSYNC, 11, 1, 0, 0, 0, 4, 15, 1, 1);
        tbl[21] = mk(OP_VSYNC,  1, 1, 0, 0, 0, 4, 15, 1, 1);

        wait_neg(2);
        check("rst_begin_frame", 32'(begin_frame), 32'd0);
        check("rst_swap", 32'(swap), 32'd0);
        check("rst_frame_count", 32'(frame_count), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 22; i++) run_step(i, tbl[i]);

        // One-cycle reset in DRAIN with frame_pix held high through release.
        frame_pix = 1'b1;
        wait_neg(6);
        rst = 1'b1;
        wait_neg(1);
        rst = 1'b0;
        check("midrst_frame_count", 32'(frame_count), 32'd0);
        check("midrst_drop_count", 32'(drop_count), 32'd0);
        check("midrst_timeout_err", 32'(timeout_err), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_swap", 32'(swap), 32'd0);
        wait_neg(20);
        check("held_high_busy", 32'(busy), 32'd0);
        check("held_high_frame_count", 32'(frame_count), 32'd0);
        frame_pix = 1'b0;
        wait_neg(4);
        run_step(22, mk(OP_VSYNC, 1, 0, 0, 1, 0, 0, 0, 1, 0));

        wait_neg(2);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_scheduler.md
FRAME_SCHEDULER -- requirements
Module: frame_scheduler

Interface
REQ-001 The module SHALL expose parameter DRAIN_CYCLES, default 4: consecutive idle cycles required before a frame counts as complete.
REQ-002 The module SHALL expose parameter TIMEOUT_CYCLES, default 2_000_000: maximum clk cycles allowed in RENDER.
REQ-003 The module SHALL expose parameter CNT_W, default 16: width of the frame and drop counters.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, declared first: clk  in  1  render-domain clock; rst  in  1  synchronous active-high reset.
REQ-005 frame_pix  in  1  raw frame-start level from the pixel domain (asynchronous).
REQ-006 draw_done  in  1  one-cycle pulse from the frame driver: all triangles have been fed.
REQ-007 renderer_busy  in  1  render manager busy.
REQ-008 pipe_valid  in  1  depth-buffer output valid, meaning a write is still in flight.
REQ-009 begin_frame  out  1  one-cycle pulse that starts the frame driver and render manager.
REQ-010 swap  out  1  one-cycle pulse that swaps the double framebuffer.
REQ-011 frame_count  out  CNT_W  number of completed frames swapped.
REQ-012 drop_count  out  CNT_W  number of vsyncs missed because of overrun.
REQ-013 timeout_err  out  1  sticky flag: a render watchdog expiry occurred.
REQ-014 busy  out  1  high in RENDER or DRAIN.

Function
REQ-015 frame_pix SHALL pass through a 2-flop synchronizer followed by rising-edge detection, giving vsync_p exactly 3 clk cycles after a frame_pix rise.
REQ-016 The state machine SHALL have four states: IDLE, RENDER, DRAIN, DONE.
REQ-017 IDLE: on vsync_p, begin_frame=1 for one cycle, swap=0, next state RENDER.
REQ-018 DONE: on vsync_p, swap=1 and begin_frame=1 in the same cycle, frame_count increments (wrapping), next state RENDER.
REQ-019 RENDER or DRAIN: on vsync_p, no begin_frame, no swap, drop_count increments and saturates at all-ones, state is unchanged.
REQ-020 RENDER: on draw_done, next state DRAIN and the idle counter clears.
REQ-021 RENDER: a watchdog counter SHALL clear on entry and increment each cycle; when it reaches TIMEOUT_CYCLES-1, timeout_err is set and the next state is DRAIN.
REQ-022 DRAIN: the idle counter SHALL increment on cycles with renderer_busy=0 and pipe_valid=0, and clear on any other cycle; when it reaches DRAIN_CYCLES-1 on an idle cycle, the next state is DONE.
REQ-023 If vsync_p and draw_done occur in the same cycle in RENDER, the drop is counted and the transition to DRAIN still happens.
REQ-024 draw_done SHALL be ignored outside RENDER.
REQ-025 begin_frame and swap SHALL be registered outputs, asserted in the cycle after vsync_p is sampled in IDLE or DONE, and never asserted for more than one cycle per vsync.

Reset
REQ-026 During rst: state=IDLE, begin_frame=0, swap=0, frame_count=0, drop_count=0, timeout_err=0, busy=0, all internal counters and synchronizer flops cleared.
REQ-027 Reset asserted mid-frame SHALL abandon the frame without emitting swap; after release, the first vsync_p is treated as an IDLE start.
REQ-028 The edge detector SHALL NOT produce vsync_p on the first cycle after reset release when frame_pix is already high.

Structure
REQ-029 The enum frame_sched_state_t (IDLE, RENDER, DRAIN, DONE) SHALL live in a shared package, raster_ctrl_pkg, for debug visibility from top level.
REQ-030 The synchronizer plus edge detector SHALL be a separate sub-module, pulse_sync, because it is reused for other cross-domain frame strobes.
REQ-031 Parameter defaults are fixed in the module; DRAIN_CYCLES and TIMEOUT_CYCLES SHALL be overridable for simulation.

Verification
REQ-032 Rise frame_pix from reset with DRAIN_CYCLES=4 -> begin_frame pulse at cycle 4 after the rise, swap=0, busy=1.
REQ-033 draw_done 100 cycles after begin, renderer_busy low, then a second vsync -> DONE after 4 idle cycles; vsync gives swap=begin_frame=1 together and frame_count=1.
REQ-034 Hold renderer_busy=1 across 3 vsyncs after draw_done -> drop_count=3, no swap; release busy -> DONE after 4 cycles.
REQ-035 Set TIMEOUT_CYCLES=50 and never assert draw_done -> timeout_err=1 at cycle 50 in RENDER, then DRAIN -> DONE.
REQ-036 Force drop_count to 16'hFFFF, then overrun once -> drop_count stays 16'hFFFF.
REQ-037 Assert rst for 1 cycle during DRAIN -> all outputs reset, no swap; with frame_pix held high, no vsync_p until its next rise.
